// File: rtl/cpu_mem_stage_if.sv
// cpu_mem_stage_if: data memory port between the stage (master) and memory (slave)
// dmem_req/dmem_we/dmem_addr/dmem_wdata: request, held until dmem_ack
// dmem_ack/dmem_rdata: completion strobe and load data from memory
interface cpu_mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/cpu_mem_stage.sv
// cpu_mem_stage: stage 3->4 with data memory access, branch resolution and push-value selection
module cpu_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TYPE_W  = 3,
  parameter int IMM_W   = 16,
  parameter int INSTR_W = 48,
  parameter int POP_W   = 11
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     valid_3a,
  output logic                     ready_3a,
  input  logic [DATA_W-1:0]        alu__out_3a,
  input  logic                     alu__cond_3a,
  input  logic [DATA_W-1:0]        st__data_3a,
  input  logic [1:0]               c__branch_3a,
  input  logic [1:0]               c__to_push_3a,
  input  logic [1:0]               c__mem_3a,
  input  logic [INSTR_W-1:0]       instr_3a,
  input  logic [DATA_W-1:0]        pc_3a,
  input  logic [POP_W-1:0]         st__to_pop_3a,
  output logic                     valid_4a,
  input  logic                     ready_4a,
  output logic                     kill_4a,
  output logic [DATA_W-1:0]        branch_target_4a,
  output logic [1:0]               c__to_push_4a,
  output logic [TYPE_W+DATA_W-1:0] st__to_push_4a,
  output logic [POP_W-1:0]         st__to_pop_4a,
  output logic [DATA_W-1:0]        pc_4a,
  cpu_mem_stage_if.master          mem
);
  localparam logic [1:0] UC_BR_NONE = 2'd0, UC_BR_REL = 2'd1, UC_BR_REL_COND = 2'd2, UC_BR_ABS = 2'd3;
  localparam logic [1:0] UC_PUSHNONE = 2'd0, UC_PUSHALU = 2'd1, UC_PUSHIMM = 2'd2, UC_PUSHLOAD = 2'd3;
  localparam logic [1:0] UC_MEM_LD = 2'd1, UC_MEM_ST = 2'd2;
  localparam logic [TYPE_W-1:0] TYPE_INTEGER = TYPE_W'(1);
  typedef enum logic {IDLE, MEM} state_t;
  state_t                    state;
  logic                      kill_pend;
  logic                      load_pend;
  logic                      acc;
  logic                      is_mem;
  logic                      ack;
  logic                      kill_nxt;
  logic [DATA_W-1:0]         imm_ext;
  logic [DATA_W-1:0]         tgt_nxt;
  logic [TYPE_W+DATA_W-1:0]  push_nxt;
  logic                      unused;
  assign unused   = ^instr_3a;
  assign ready_3a = state == IDLE && (!valid_4a || ready_4a);
  assign acc      = valid_3a && ready_3a;
  assign is_mem   = c__mem_3a == UC_MEM_LD || c__mem_3a == UC_MEM_ST;
  assign ack      = state == MEM && mem.dmem_ack;
  assign kill_4a  = valid_4a && kill_pend;
  assign imm_ext  = DATA_W'($signed(instr_3a[IMM_W-1:0]));
  always_comb begin
    kill_nxt = c__branch_3a == UC_BR_REL || c__branch_3a == UC_BR_ABS ||
               (c__branch_3a == UC_BR_REL_COND && alu__cond_3a);
    tgt_nxt  = c__branch_3a == UC_BR_ABS  ? alu__out_3a :
               c__branch_3a == UC_BR_NONE ? '0 : pc_3a + imm_ext;
    push_nxt = c__to_push_3a == UC_PUSHALU  ? {TYPE_INTEGER, alu__out_3a} :
               c__to_push_3a == UC_PUSHIMM  ? instr_3a[TYPE_W+DATA_W-1:0] :
               c__to_push_3a == UC_PUSHLOAD ? {TYPE_INTEGER, {DATA_W{1'b0}}} : '0;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state            <= IDLE;
      valid_4a         <= 1'b0;
      kill_pend        <= 1'b0;
      load_pend        <= 1'b0;
      branch_target_4a <= '0;
      c__to_push_4a    <= '0;
      st__to_push_4a   <= '0;
      st__to_pop_4a    <= '0;
      pc_4a            <= '0;
      mem.dmem_req     <= 1'b0;
      mem.dmem_we      <= 1'b0;
      mem.dmem_addr    <= '0;
      mem.dmem_wdata   <= '0;
    end else if (acc) begin
      state            <= is_mem ? MEM : IDLE;
      valid_4a         <= !is_mem;
      kill_pend        <= kill_nxt;
      load_pend        <= c__to_push_3a == UC_PUSHLOAD && c__mem_3a == UC_MEM_LD;
      branch_target_4a <= tgt_nxt;
      c__to_push_4a    <= c__to_push_3a;
      st__to_push_4a   <= push_nxt;
      st__to_pop_4a    <= st__to_pop_3a;
      pc_4a            <= pc_3a;
      mem.dmem_req     <= is_mem;
      mem.dmem_we      <= c__mem_3a == UC_MEM_ST;
      if (is_mem) begin
        mem.dmem_addr  <= alu__out_3a;
        mem.dmem_wdata <= c__mem_3a == UC_MEM_ST ? st__data_3a : '0;
      end
    end else if (ack) begin
      state            <= IDLE;
      valid_4a         <= 1'b1;
      mem.dmem_req     <= 1'b0;
      mem.dmem_we      <= 1'b0;
      if (load_pend) st__to_push_4a[DATA_W-1:0] <= mem.dmem_rdata;
    end else if (ready_4a) begin
      valid_4a         <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_mem_stage.sv
// tb_cpu_mem_stage: table vectors, directed corner sequences and randomized run against a transaction model
module tb_cpu_mem_stage;
  localparam logic [1:0] BR_NONE = 2'd0, BR_REL = 2'd1, BR_RELC = 2'd2, BR_ABS = 2'd3;
  localparam logic [1:0] P_NONE = 2'd0, P_ALU = 2'd1, P_IMM = 2'd2, P_LOAD = 2'd3;
  localparam logic [1:0] M_NONE = 2'd0, M_LD = 2'd1, M_ST = 2'd2, M_RSV = 2'd3;
  logic        clk = 1'b0, rst_b = 1'b1;
  logic        valid_3a = 1'b0, ready_3a, alu__cond_3a = 1'b0, valid_4a, ready_4a = 1'b0, kill_4a;
  logic [31:0] alu__out_3a = '0, st__data_3a = '0, pc_3a = '0, branch_target_4a, pc_4a;
  logic [1:0]  c__branch_3a = '0, c__to_push_3a = '0, c__mem_3a = '0, c__to_push_4a;
  logic [47:0] instr_3a = '0;
  logic [10:0] st__to_pop_3a = '0, st__to_pop_4a;
  logic [34:0] st__to_push_4a;
  int          n_chk = 0, n_pass = 0, n_xfer = 0;
  cpu_mem_stage_if #(.DATA_W(32)) mem();
  cpu_mem_stage dut (
    .clk(clk), .rst_b(rst_b), .valid_3a(valid_3a), .ready_3a(ready_3a),
    .alu__out_3a(alu__out_3a), .alu__cond_3a(alu__cond_3a), .st__data_3a(st__data_3a),
    .c__branch_3a(c__branch_3a), .c__to_push_3a(c__to_push_3a), .c__mem_3a(c__mem_3a),
    .instr_3a(instr_3a), .pc_3a(pc_3a), .st__to_pop_3a(st__to_pop_3a),
    .valid_4a(valid_4a), .ready_4a(ready_4a), .kill_4a(kill_4a),
    .branch_target_4a(branch_target_4a), .c__to_push_4a(c__to_push_4a),
    .st__to_push_4a(st__to_push_4a), .st__to_pop_4a(st__to_pop_4a), .pc_4a(pc_4a),
    .mem(mem)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (valid_4a && ready_4a) n_xfer <= n_xfer + 1;
  typedef struct {
    logic        kill;
    logic [31:0] tgt;
    logic [34:0] push;
    logic [1:0]  cp;
    logic [31:0] pc;
    logic [10:0] pop;
    bit          ldp;
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;
  typedef struct {
    logic [1:0]  br, push, m;
    logic        cond;
    logic [31:0] alu, pc;
    logic [47:0] ins;
    logic        kill;
    logic [31:0] tgt;
    logic [34:0] pushv;
  } vec_t;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] br, input logic [1:0] p, input logic [1:0] m,
                       input logic cond, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] pc, input logic [47:0] ins, input logic [10:0] pop);
    c__branch_3a = br; c__to_push_3a = p; c__mem_3a = m; alu__cond_3a = cond;
    alu__out_3a = alu; st__data_3a = sd; pc_3a = pc; instr_3a = ins; st__to_pop_3a = pop;
    valid_3a = 1'b1;
  endtask
  // Expected stage-4 bundle from the stage-3 inputs currently driven, using plain integer arithmetic
  function automatic exp_t model();
    exp_t   e;
    longint off;
    off = longint'(instr_3a[15:0]);
    if (off >= 32768) off -= 65536;
    e.kill   = c__branch_3a == BR_REL || c__branch_3a == BR_ABS || (c__branch_3a == BR_RELC && alu__cond_3a);
    e.tgt    = c__branch_3a == BR_ABS ? alu__out_3a : c__branch_3a == BR_NONE ? 32'h0 : 32'(longint'(pc_3a) + off);
    e.push   = c__to_push_3a == P_ALU ? {3'd1, alu__out_3a} : c__to_push_3a == P_IMM ? instr_3a[34:0] :
               c__to_push_3a == P_LOAD ? {3'd1, 32'h0} : 35'h0;
    e.cp     = c__to_push_3a;
    e.pc     = pc_3a;
    e.pop    = st__to_pop_3a;
    e.is_mem = c__mem_3a == M_LD || c__mem_3a == M_ST;
    e.ldp    = c__to_push_3a == P_LOAD && c__mem_3a == M_LD;
    e.we     = c__mem_3a == M_ST;
    e.addr   = alu__out_3a;
    e.wdata  = e.we ? st__data_3a : 32'h0;
    return e;
  endfunction
  task automatic chk_out(string tag, exp_t e);
    chk({tag, " kill"}, kill_4a, e.kill);
    chk({tag, " target"}, branch_target_4a, e.tgt);
    chk({tag, " push"}, st__to_push_4a, e.push);
    chk({tag, " c_push"}, c__to_push_4a, e.cp);
    chk({tag, " pc"}, pc_4a, e.pc);
    chk({tag, " pop"}, st__to_pop_4a, e.pop);
  endtask
  vec_t vt[9];
  exp_t q[$];
  exp_t pend, cur, e;
  bit   have_pend, acc, xfer, ackd, drain;
  int   wait_cnt, x0;
  logic [31:0] rd;
  initial begin
    mem.dmem_ack = 1'b0;
    mem.dmem_rdata = '0;
    vt[0] = '{BR_REL,  P_NONE, M_NONE, 1'b0, 32'h0,        32'h100,      48'h0000_0000_FFF0, 1'b1, 32'hF0,       35'h0};
    vt[1] = '{BR_RELC, P_ALU,  M_NONE, 1'b0, 32'h12345678, 32'h200,      48'h0000_0000_0010, 1'b0, 32'h210,      35'h1_1234_5678};
    vt[2] = '{BR_RELC, P_NONE, M_NONE, 1'b1, 32'h0,        32'hFFFFFFF0, 48'h0000_0000_0020, 1'b1, 32'h10,       35'h0};
    vt[3] = '{BR_ABS,  P_ALU,  M_NONE, 1'b0, 32'hCAFEF00D, 32'h40,       48'h0000_0000_1234, 1'b1, 32'hCAFEF00D, 35'h1_CAFE_F00D};
    vt[4] = '{BR_NONE, P_IMM,  M_NONE, 1'b1, 32'h9,        32'h44,       48'hFFFE_8765_4321, 1'b0, 32'h0,        35'h6_8765_4321};
    vt[5] = '{BR_NONE, P_LOAD, M_NONE, 1'b0, 32'h77,       32'h48,       48'h0,              1'b0, 32'h0,        35'h1_0000_0000};
    vt[6] = '{BR_REL,  P_NONE, M_NONE, 1'b0, 32'h0,        32'h0,        48'h0000_0000_7FFF, 1'b1, 32'h7FFF,     35'h0};
    vt[7] = '{BR_REL,  P_IMM,  M_NONE, 1'b0, 32'h0,        32'h10000,    48'h0000_0000_8000, 1'b1, 32'h8000,     35'h0_0000_8000};
    vt[8] = '{BR_ABS,  P_ALU,  M_RSV,  1'b1, 32'h5,        32'h4C,       48'h0,              1'b1, 32'h5,        35'h1_0000_0005};
    // asynchronous reset with no clock edge involved
    #1 rst_b = 1'b0;
    #1;
    chk("rst valid_4a", valid_4a, 0);
    chk("rst kill_4a", kill_4a, 0);
    chk("rst dmem_req", mem.dmem_req, 0);
    chk("rst dmem_we", mem.dmem_we, 0);
    chk("rst push", st__to_push_4a, 0);
    chk("rst target", branch_target_4a, 0);
    chk("rst ready_3a", ready_3a, 1);
    tick;
    tick;
    rst_b = 1'b1;
    // single-cycle bundles, applied back to back
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].br, vt[i].push, vt[i].m, vt[i].cond, vt[i].alu, 32'h0, vt[i].pc, vt[i].ins, 11'(i * 3 + 1));
      ready_4a = 1'b1;
      tick;
      valid_3a = 1'b0;
      chk($sformatf("tbl%0d valid_4a", i), valid_4a, 1);
      chk($sformatf("tbl%0d ready_3a", i), ready_3a, 1);
      chk($sformatf("tbl%0d kill", i), kill_4a, vt[i].kill);
      chk($sformatf("tbl%0d target", i), branch_target_4a, vt[i].tgt);
      chk($sformatf("tbl%0d push", i), st__to_push_4a, vt[i].pushv);
      chk($sformatf("tbl%0d c_push", i), c__to_push_4a, vt[i].push);
      chk($sformatf("tbl%0d pc", i), pc_4a, vt[i].pc);
      chk($sformatf("tbl%0d pop", i), st__to_pop_4a, 11'(i * 3 + 1));
      chk($sformatf("tbl%0d dmem_req", i), mem.dmem_req, 0);
    end
    tick;
    chk("tbl drain valid_4a", valid_4a, 0);
    chk("tbl drain kill_4a", kill_4a, 0);
    // load, ack three cycles after the request appears
    drive(BR_NONE, P_LOAD, M_LD, 1'b0, 32'h40, 32'h55, 32'h300, 48'h0, 11'h3);
    tick;
    valid_3a = 1'b0;
    chk("ld req", mem.dmem_req, 1);
    chk("ld we", mem.dmem_we, 0);
    chk("ld addr", mem.dmem_addr, 32'h40);
    chk("ld wdata", mem.dmem_wdata, 0);
    chk("ld valid_4a early", valid_4a, 0);
    chk("ld ready_3a", ready_3a, 0);
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("ld hold req", mem.dmem_req, 1);
      chk("ld hold addr", mem.dmem_addr, 32'h40);
      chk("ld hold ready_3a", ready_3a, 0);
      chk("ld hold valid_4a", valid_4a, 0);
    end
    mem.dmem_ack = 1'b1;
    mem.dmem_rdata = 32'hDEADBEEF;
    tick;
    mem.dmem_ack = 1'b0;
    mem.dmem_rdata = 32'h0;
    chk("ld done valid_4a", valid_4a, 1);
    chk("ld done req", mem.dmem_req, 0);
    chk("ld done push", st__to_push_4a, 35'h1_DEAD_BEEF);
    chk("ld done pc", pc_4a, 32'h300);
    tick;
    chk("ld after valid_4a", valid_4a, 0);
    // store acked in its first request cycle
    drive(BR_NONE, P_ALU, M_ST, 1'b0, 32'h80, 32'h1234, 32'h304, 48'h0, 11'h4);
    tick;
    valid_3a = 1'b0;
    chk("st req", mem.dmem_req, 1);
    chk("st we", mem.dmem_we, 1);
    chk("st addr", mem.dmem_addr, 32'h80);
    chk("st wdata", mem.dmem_wdata, 32'h1234);
    mem.dmem_ack = 1'b1;
    mem.dmem_rdata = 32'hFFFFFFFF;
    tick;
    mem.dmem_ack = 1'b0;
    chk("st done we", mem.dmem_we, 0);
    chk("st done req", mem.dmem_req, 0);
    chk("st done valid_4a", valid_4a, 1);
    chk("st done push", st__to_push_4a, 35'h1_0000_0080);
    tick;
    chk("st after valid_4a", valid_4a, 0);
    // downstream stall with an immediate push pending
    ready_4a = 1'b0;
    drive(BR_REL, P_IMM, M_NONE, 1'b0, 32'h0, 32'h0, 32'h400, 48'h0003_1111_0008, 11'h7FF);
    tick;
    drive(BR_ABS, P_ALU, M_NONE, 1'b0, 32'h99, 32'h0, 32'h500, 48'h0, 11'h1);
    x0 = n_xfer;
    for (int k = 0; k < 4; k++) begin
      chk("bp valid_4a", valid_4a, 1);
      chk("bp push", st__to_push_4a, 35'h3_1111_0008);
      chk("bp target", branch_target_4a, 32'h408);
      chk("bp kill", kill_4a, 1);
      chk("bp ready_3a", ready_3a, 0);
      tick;
    end
    valid_3a = 1'b0;
    ready_4a = 1'b1;
    tick;
    chk("bp release valid_4a", valid_4a, 0);
    chk("bp transfers", n_xfer - x0, 1);
    // conditional branch not taken then taken, back to back
    drive(BR_RELC, P_NONE, M_NONE, 1'b0, 32'h0, 32'h0, 32'h500, 48'h4, 11'h0);
    tick;
    drive(BR_RELC, P_NONE, M_NONE, 1'b1, 32'h0, 32'h0, 32'h600, 48'h4, 11'h0);
    chk("rc0 valid_4a", valid_4a, 1);
    chk("rc0 kill", kill_4a, 0);
    tick;
    valid_3a = 1'b0;
    chk("rc1 kill", kill_4a, 1);
    chk("rc1 target", branch_target_4a, 32'h604);
    tick;
    chk("rc end kill", kill_4a, 0);
    chk("rc end valid_4a", valid_4a, 0);
    // reset while a load is outstanding
    drive(BR_NONE, P_LOAD, M_LD, 1'b0, 32'h44, 32'h0, 32'h700, 48'h0, 11'h0);
    tick;
    valid_3a = 1'b0;
    chk("rmem req", mem.dmem_req, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("rmem async req", mem.dmem_req, 0);
    chk("rmem async valid_4a", valid_4a, 0);
    chk("rmem async pc", pc_4a, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    mem.dmem_ack = 1'b1;
    tick;
    tick;
    mem.dmem_ack = 1'b0;
    chk("rmem stray ack req", mem.dmem_req, 0);
    chk("rmem stray ack valid_4a", valid_4a, 0);
    chk("rmem ready_3a", ready_3a, 1);
    // randomized traffic against the transaction model
    have_pend = 0;
    wait_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drain = cyc >= 2940;
      if (!drain && $urandom_range(0, 2) != 0)
        drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom),
              $urandom, $urandom, $urandom, 48'({$urandom, $urandom}), 11'($urandom));
      else valid_3a = 1'b0;
      ready_4a = drain || $urandom_range(0, 3) != 0;
      if (mem.dmem_req) begin
        mem.dmem_ack = wait_cnt == 0;
        if (wait_cnt > 0) wait_cnt--;
      end else mem.dmem_ack = $urandom_range(0, 5) == 0;
      mem.dmem_rdata = $urandom;
      #1;
      acc  = valid_3a && ready_3a;
      xfer = valid_4a && ready_4a;
      ackd = mem.dmem_ack && mem.dmem_req;
      rd   = mem.dmem_rdata;
      cur  = model();
      if (xfer) begin
        if (q.size() == 0) chk("rnd unexpected output", 1, 0);
        else begin
          e = q.pop_front();
          chk_out("rnd", e);
        end
      end
      if (mem.dmem_req) begin
        if (!have_pend) chk("rnd unexpected req", 1, 0);
        else begin
          chk("rnd addr", mem.dmem_addr, pend.addr);
          chk("rnd we", mem.dmem_we, pend.we);
          chk("rnd wdata", mem.dmem_wdata, pend.wdata);
        end
      end
      if (!valid_4a) chk("rnd kill while invalid", kill_4a, 0);
      @(posedge clk);
      #1;
      if (ackd) begin
        if (pend.ldp) pend.push = {3'd1, rd};
        q.push_back(pend);
        have_pend = 0;
      end
      if (acc) begin
        if (cur.is_mem) begin
          pend = cur;
          have_pend = 1;
          wait_cnt = $urandom_range(0, 3);
        end else q.push_back(cur);
      end
    end
    chk("rnd drained", q.size() + int'(have_pend), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
